// File: rtl/emsensor_poll_ctrl.sv
// Purpose : periodically polls an APB alarm sensor and latches/counts alarms, optionally refreshing the sensor.
// Latency : read visible in EVAL 2 cycles after RD_SETUP; refresh writes finish 5 cycles after RD_ACCESS.
// Backpress: none; APB slave assumed zero-wait, a started sequence always runs to completion.
//
// Ports
//   vrst, vclk        async active-low reset, single rising-edge clock
//   enable            polling enable (dropping it lets the current sequence finish, then idles)
//   poll_period       WAIT length is poll_period+1 cycles, sampled when WAIT is entered
//   auto_refresh      sampled in EVAL: after an alarm write 1 then 0 to the refresh control word
//   clr_irq           single-cycle clear of the sticky irq (a simultaneous alarm wins)
//   m_psel..m_prdata  APB master; only m_psel[SEL_IDX] is ever driven high
//   irq, alarm_cnt,   sticky alarm flag, saturating alarm counter, last nonzero alarm word
//   last_alarm, busy  busy is high from RD_SETUP through the final write ACCESS
module emsensor_poll_ctrl #(
    parameter int POLL_W  = 16,
    parameter int SEL_IDX = 0
) (
    input  logic              vrst,
    input  logic              vclk,
    input  logic              enable,
    input  logic [POLL_W-1:0] poll_period,
    input  logic              auto_refresh,
    input  logic              clr_irq,
    output logic [7:0]        m_psel,
    output logic              m_penable,
    output logic [31:0]       m_paddr,
    output logic              m_pwrite,
    output logic [31:0]       m_pwdata,
    input  logic [31:0]       m_prdata,
    output logic              irq,
    output logic [15:0]       alarm_cnt,
    output logic [31:0]       last_alarm,
    output logic              busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT      = 4'd1,
        ST_RD_SETUP  = 4'd2,
        ST_RD_ACCESS = 4'd3,
        ST_EVAL      = 4'd4,
        ST_W1_SETUP  = 4'd5,
        ST_W1_ACCESS = 4'd6,
        ST_W0_SETUP  = 4'd7,
        ST_W0_ACCESS = 4'd8
    } state_t;

    localparam logic [9:0] IDX_CTRL  = 10'd0;   // refresh control word
    localparam logic [9:0] IDX_ALARM = 10'd1;   // alarm status word
    localparam logic [7:0] PSEL_ONE  = 8'(1) << SEL_IDX;

    state_t            state;
    state_t            state_nxt;
    state_t            rest_state;
    logic              rst_done;
    logic [POLL_W-1:0] cnt;
    logic [31:0]       rd_word;
    logic              irq_q;
    logic [15:0]       alarm_cnt_q;
    logic [31:0]       last_alarm_q;
    logic              wait_entry;
    logic              eval_alarm;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holds IDLE for one extra edge after reset release so the first
    // transfer cannot start on the very first edge out of reset.
    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rest_state = enable ? ST_WAIT : ST_IDLE;
        state_nxt  = state;
        case (state)
            ST_IDLE: begin
                if (rst_done && enable) begin
                    state_nxt = ST_RD_SETUP;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = ST_RD_SETUP;
                end
            end
            ST_RD_SETUP:  state_nxt = ST_RD_ACCESS;
            ST_RD_ACCESS: state_nxt = ST_EVAL;
            ST_EVAL: begin
                if ((rd_word != 32'd0) && auto_refresh) begin
                    state_nxt = ST_W1_SETUP;
                end else begin
                    state_nxt = rest_state;
                end
            end
            ST_W1_SETUP:  state_nxt = ST_W1_ACCESS;
            ST_W1_ACCESS: state_nxt = ST_W0_SETUP;
            ST_W0_SETUP:  state_nxt = ST_W0_ACCESS;
            ST_W0_ACCESS: state_nxt = rest_state;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (pure function of state, so reset clears it at once)
    // ------------------------------------------------------------------
    always_comb begin
        m_psel    = 8'd0;
        m_penable = 1'b0;
        m_paddr   = 32'd0;
        m_pwrite  = 1'b0;
        m_pwdata  = 32'd0;
        busy      = 1'b0;
        case (state)
            ST_RD_SETUP, ST_RD_ACCESS: begin
                m_psel    = PSEL_ONE;
                m_penable = (state == ST_RD_ACCESS);
                m_paddr   = {20'd0, IDX_ALARM, 2'b00};
                busy      = 1'b1;
            end
            ST_EVAL: begin
                busy = 1'b1;
            end
            ST_W1_SETUP, ST_W1_ACCESS: begin
                m_psel    = PSEL_ONE;
                m_penable = (state == ST_W1_ACCESS);
                m_paddr   = {20'd0, IDX_CTRL, 2'b00};
                m_pwrite  = 1'b1;
                m_pwdata  = 32'd1;
                busy      = 1'b1;
            end
            ST_W0_SETUP, ST_W0_ACCESS: begin
                m_psel    = PSEL_ONE;
                m_penable = (state == ST_W0_ACCESS);
                m_paddr   = {20'd0, IDX_CTRL, 2'b00};
                m_pwrite  = 1'b1;
                m_pwdata  = 32'd0;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: wait counter, read capture, alarm bookkeeping
    // ------------------------------------------------------------------
    assign wait_entry = (state_nxt == ST_WAIT) && (state != ST_WAIT);
    assign eval_alarm = (state == ST_EVAL) && (rd_word != 32'd0);

    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            cnt <= '0;
        end else if (wait_entry) begin
            cnt <= poll_period;
        end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - POLL_W'(1);
        end
    end

    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            rd_word <= 32'd0;
        end else if (state == ST_RD_ACCESS) begin
            rd_word <= m_prdata;
        end
    end

    // Alarm set takes priority over a same-cycle clear.
    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            irq_q <= 1'b0;
        end else if (eval_alarm) begin
            irq_q <= 1'b1;
        end else if (clr_irq) begin
            irq_q <= 1'b0;
        end
    end

    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            alarm_cnt_q  <= 16'd0;
            last_alarm_q <= 32'd0;
        end else if (eval_alarm) begin
            last_alarm_q <= rd_word;
            if (alarm_cnt_q != 16'hFFFF) begin
                alarm_cnt_q <= alarm_cnt_q + 16'd1;
            end
        end
    end

    assign irq        = irq_q;
    assign alarm_cnt  = alarm_cnt_q;
    assign last_alarm = last_alarm_q;

endmodule

// File: doc/emsensor_poll_ctrl.md
EMSENSOR_POLL_CTRL -- requirements
Module: emsensor_poll_ctrl

Interface
REQ-001 SHALL have parameter POLL_W, 16, width of poll-period counter.
REQ-002 SHALL have parameter SEL_IDX, 0, bit of m_psel driven as the sensor select (0..7).
REQ-003 SHALL have port vrst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port vclk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port enable  input  1  polling enable.
REQ-006 SHALL have port poll_period  input  POLL_W  WAIT-state length control, sampled on WAIT entry.
REQ-007 SHALL have port auto_refresh  input  1  when 1, refresh sensor after each alarm.
REQ-008 SHALL have port clr_irq  input  1  single-cycle irq clear.
REQ-009 SHALL have port m_psel  output  8  APB select, only bit SEL_IDX ever set.
REQ-010 SHALL have port m_penable  output  1  APB enable.
REQ-011 SHALL have port m_paddr  output  32  APB address; only bits [11:2] nonzero.
REQ-012 SHALL have port m_pwrite  output  1  APB write strobe.
REQ-013 SHALL have port m_pwdata  output  32  APB write data.
REQ-014 SHALL have port m_prdata  input  32  APB read data from sensor.
REQ-015 SHALL have port irq  output  1  sticky alarm interrupt.
REQ-016 SHALL have port alarm_cnt  output  16  alarms detected, saturating.
REQ-017 SHALL have port last_alarm  output  32  last nonzero alarm word read.
REQ-018 SHALL have port busy  output  1  high while an APB sequence is in progress.

Function
REQ-019 SHALL implement states IDLE, WAIT, RD_SETUP, RD_ACCESS, EVAL, W1_SETUP, W1_ACCESS, W0_SETUP, W0_ACCESS.
REQ-020 SHALL map registers: alarm status word index 1 (m_paddr[11:2]=1, byte 0x004); refresh control word index 0 (0x000).
REQ-021 SHALL drive every transfer as zero-wait APB: SETUP cycle (psel bit=1, penable=0), then ACCESS cycle (psel bit=1, penable=1); address/pwrite/pwdata stable across both.
REQ-022 SHALL drive m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0 in IDLE, WAIT, EVAL.
REQ-023 IDLE: enable=1 -> RD_SETUP next cycle (first poll without delay).
REQ-024 WAIT entry SHALL load counter with poll_period; counter==0 -> RD_SETUP, else decrement; WAIT lasts poll_period+1 cycles (0 gives 1 cycle).
REQ-025 RD_SETUP -> RD_ACCESS; m_prdata SHALL be registered at the rising edge ending RD_ACCESS, then -> EVAL.
REQ-026 EVAL with registered word != 0: set irq, last_alarm <= word, alarm_cnt += 1 saturating at 0xFFFF; then -> W1_SETUP if auto_refresh=1, else WAIT.
REQ-027 EVAL with word == 0: no flag/counter change; -> WAIT.
REQ-028 W1 pair SHALL write 0x00000001 to index 0; W0 pair SHALL then write 0x00000000 to index 0; W0_ACCESS -> WAIT.
REQ-029 Alarm-to-refresh-complete latency SHALL be 5 cycles after RD_ACCESS (EVAL + 4 write cycles).
REQ-030 enable=0 SHALL never abort a started sequence: from RD_SETUP onward, sequence completes, then -> IDLE instead of WAIT; enable=0 in WAIT -> IDLE next cycle.
REQ-031 clr_irq=1 SHALL clear irq next edge; simultaneous EVAL alarm set SHALL win (irq stays 1).
REQ-032 busy SHALL be 1 in RD_*, EVAL, W1_*, W0_* and 0 in IDLE, WAIT.
REQ-033 auto_refresh SHALL be sampled in EVAL only; changes mid-write ignored.

Reset
REQ-034 vrst=0 SHALL asynchronously force state IDLE, counter 0, all APB outputs 0, irq=0, alarm_cnt=0, last_alarm=0, busy=0, including mid-transfer.
REQ-035 First transfer SHALL start no earlier than the second rising edge after vrst deasserts with enable=1.

Verification
REQ-036 Reset release, enable=1, poll_period=3, m_prdata=0 -> reads of 0x004 every 7 cycles (2 APB + EVAL + 4 WAIT), irq=0, alarm_cnt=0.
REQ-037 m_prdata=0x00000001 during a read, auto_refresh=1 -> irq=1, alarm_cnt=1, last_alarm=0x00000001, then write 0x1 then 0x0 to 0x000 in 4 consecutive cycles.
REQ-038 Same alarm with auto_refresh=0 -> irq=1, no write transfers, next read after WAIT; alarm_cnt increments every poll while alarm persists.
REQ-039 clr_irq pulsed in same cycle as EVAL alarm -> irq remains 1; clr_irq alone -> irq=0 next cycle.
REQ-040 alarm_cnt preloaded to 0xFFFE via 2 more alarms beyond -> holds 0xFFFF, no wrap.
REQ-041 enable dropped during W1_SETUP -> W1 and W0 pairs complete, then IDLE; vrst asserted during RD_ACCESS -> all outputs 0 same cycle.
